ball_motion_sched: RTL and testbench

- Per-frame motion scheduler for up to CNT balls.
- On each frame tick it visits every ball slot in turn and computes a candidate next position, applying wall reflection and bottom-loss rules.
- For live balls it arbitrates a single shared collision checker (paddle/brick logic) through a req/ack handshake, then commits position and velocity.
- Outputs the packed xs/ys/balls vectors consumed by the ball renderer, plus spawn and loss bookkeeping.

---
 rtl/ball_motion_sched.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ball_motion_sched.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion_sched.sv
// Per-frame ball motion scheduler: walks every ball slot once per frame tick,
// reflects off the side/top walls, retires balls lost at the bottom and
// arbitrates a shared collision checker before committing each move.
module ball_motion_sched #(
    parameter int CNT   = 3,
    parameter int SCR_W = 640,
    parameter int SCR_H = 480,
    parameter int SIZE  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_tick,
    input  logic                spawn,
    input  logic [9:0]          spawn_x,
    input  logic [9:0]          spawn_y,
    input  logic [3:0]          spawn_vx,
    input  logic [3:0]          spawn_vy,
    output logic                chk_req,
    output logic [9:0]          chk_x,
    output logic [9:0]          chk_y,
    input  logic                chk_ack,
    input  logic                chk_hit_x,
    input  logic                chk_hit_y,
    output logic [CNT*10-1:0]   xs,
    output logic [CNT*10-1:0]   ys,
    output logic [CNT-1:0]      balls,
    output logic                busy,
    output logic                lost,
    output logic                spawn_full,
    output logic                overrun
);

    localparam int IW = (CNT > 1) ? $clog2(CNT) : 1;
    localparam logic signed [10:0] X_MIN = 11'(SIZE);
    localparam logic signed [10:0] X_MAX = 11'(SCR_W - 1 - SIZE);
    localparam logic signed [10:0] Y_MIN = 11'(SIZE);
    localparam logic signed [10:0] Y_MAX = 11'(SCR_H - 1 - SIZE);

    typedef enum logic [2:0] {S_IDLE, S_EVAL, S_QUERY, S_COMMIT, S_DONE} state_t;

    // Two's complement negate, with -8 saturating to +7 instead of wrapping.
    function automatic logic signed [3:0] neg_sat(input logic signed [3:0] v);
        logic signed [3:0] r;
        if (v == -4'sd8) begin
            r = 4'sd7;
        end else begin
            r = -v;
        end
        return r;
    endfunction

    state_t                 r_state, w_state_nxt;
    logic [IW-1:0]          r_idx;
    logic [9:0]             r_x  [CNT];
    logic [9:0]             r_y  [CNT];
    logic signed [3:0]      r_vx [CNT];
    logic signed [3:0]      r_vy [CNT];
    logic [CNT-1:0]         r_balls;
    logic                   r_busy, r_lost, r_spawn_full, r_overrun;
    logic                   r_chk_req;
    logic [9:0]             r_chk_x, r_chk_y;
    logic signed [3:0]      r_nvx, r_nvy;
    logic                   r_hit_x, r_hit_y;
    logic                   r_pend;
    logic [9:0]             r_pend_x, r_pend_y;
    logic [3:0]             r_pend_vx, r_pend_vy;

    logic                   w_live, w_last, w_loss;
    logic [9:0]             w_x_cur, w_y_cur;
    logic signed [3:0]      w_vx_cur, w_vy_cur, w_nvx, w_nvy;
    logic signed [10:0]     w_nx_raw, w_ny_raw, w_nx, w_ny;
    logic                   w_free_found;
    logic [IW-1:0]          w_free_idx;

    assign w_live   = r_balls[r_idx];
    assign w_last   = (r_idx == IW'(CNT - 1));
    assign w_x_cur  = r_x[r_idx];
    assign w_y_cur  = r_y[r_idx];
    assign w_vx_cur = r_vx[r_idx];
    assign w_vy_cur = r_vy[r_idx];
    assign w_nx_raw = $signed({1'b0, w_x_cur}) + $signed({{7{w_vx_cur[3]}}, w_vx_cur});
    assign w_ny_raw = $signed({1'b0, w_y_cur}) + $signed({{7{w_vy_cur[3]}}, w_vy_cur});
    assign w_loss   = (w_ny_raw > Y_MAX);

    // Wall clamping and reflection of the candidate position.
    always_comb begin
        w_nx  = w_nx_raw;
        w_nvx = w_vx_cur;
        w_ny  = w_ny_raw;
        w_nvy = w_vy_cur;
        if (w_nx_raw < X_MIN) begin
            w_nx  = X_MIN;
            w_nvx = neg_sat(w_vx_cur);
        end else if (w_nx_raw > X_MAX) begin
            w_nx  = X_MAX;
            w_nvx = neg_sat(w_vx_cur);
        end else begin
            w_nx  = w_nx_raw;
            w_nvx = w_vx_cur;
        end
        if (w_ny_raw < Y_MIN) begin
            w_ny  = Y_MIN;
            w_nvy = neg_sat(w_vy_cur);
        end else begin
            w_ny  = w_ny_raw;
            w_nvy = w_vy_cur;
        end
    end

    // Lowest free slot for a pending spawn.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = CNT - 1; i >= 0; i--) begin
            w_free_found = w_free_found | ~r_balls[i];
            w_free_idx   = r_balls[i] ? w_free_idx : IW'(i);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   w_state_nxt = frame_tick ? S_EVAL : S_IDLE;
            S_EVAL: begin
                if (!w_live || w_loss) begin
                    w_state_nxt = w_last ? S_DONE : S_EVAL;
                end else begin
                    w_state_nxt = S_QUERY;
                end
            end
            S_QUERY:  w_state_nxt = chk_ack ? S_COMMIT : S_QUERY;
            S_COMMIT: w_state_nxt = w_last ? S_DONE : S_EVAL;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Slot state, query handshake, spawn latch and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx        <= '0;
            r_balls      <= '0;
            r_busy       <= 1'b0;
            r_lost       <= 1'b0;
            r_spawn_full <= 1'b0;
            r_overrun    <= 1'b0;
            r_chk_req    <= 1'b0;
            r_chk_x      <= '0;
            r_chk_y      <= '0;
            r_nvx        <= '0;
            r_nvy        <= '0;
            r_hit_x      <= 1'b0;
            r_hit_y      <= 1'b0;
            r_pend       <= 1'b0;
            r_pend_x     <= '0;
            r_pend_y     <= '0;
            r_pend_vx    <= '0;
            r_pend_vy    <= '0;
            for (int i = 0; i < CNT; i++) begin
                r_x[i]  <= '0;
                r_y[i]  <= '0;
                r_vx[i] <= '0;
                r_vy[i] <= '0;
            end
        end else begin
            r_lost       <= 1'b0;
            r_spawn_full <= 1'b0;
            r_overrun    <= frame_tick & r_busy;
            // A new spawn always wins over clearing the one being serviced.
            if (spawn) begin
                r_pend    <= 1'b1;
                r_pend_x  <= spawn_x;
                r_pend_y  <= spawn_y;
                r_pend_vx <= spawn_vx;
                r_pend_vy <= spawn_vy;
            end else if (r_state == S_IDLE && !frame_tick) begin
                r_pend <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (frame_tick) begin
                        r_idx  <= '0;
                        r_busy <= 1'b1;
                    end else if (r_pend) begin
                        if (w_free_found) begin
                            r_balls[w_free_idx] <= 1'b1;
                            r_x[w_free_idx]     <= r_pend_x;
                            r_y[w_free_idx]     <= r_pend_y;
                            r_vx[w_free_idx]    <= r_pend_vx;
                            r_vy[w_free_idx]    <= r_pend_vy;
                        end else begin
                            r_spawn_full <= 1'b1;
                        end
                    end
                end
                S_EVAL: begin
                    if (w_live && !w_loss) begin
                        r_chk_req <= 1'b1;
                        r_chk_x   <= w_nx[9:0];
                        r_chk_y   <= w_ny[9:0];
                        r_nvx     <= w_nvx;
                        r_nvy     <= w_nvy;
                    end else begin
                        if (w_live) begin
                            r_balls[r_idx] <= 1'b0;
                            r_lost         <= 1'b1;
                        end
                        if (!w_last) begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
                S_QUERY: begin
                    if (chk_ack) begin
                        r_chk_req <= 1'b0;
                        r_hit_x   <= chk_hit_x;
                        r_hit_y   <= chk_hit_y;
                    end
                end
                S_COMMIT: begin
                    if (!r_hit_x) begin
                        r_x[r_idx] <= r_chk_x;
                    end
                    if (!r_hit_y) begin
                        r_y[r_idx] <= r_chk_y;
                    end
                    r_vx[r_idx] <= r_hit_x ? neg_sat(r_nvx) : r_nvx;
                    r_vy[r_idx] <= r_hit_y ? neg_sat(r_nvy) : r_nvy;
                    if (!w_last) begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_DONE:  r_busy <= 1'b0;
                default: r_busy <= 1'b0;
            endcase
        end
    end

    for (genvar g = 0; g < CNT; g++) begin : g_pack
        assign xs[g*10 +: 10] = r_x[g];
        assign ys[g*10 +: 10] = r_y[g];
    end

    assign balls      = r_balls;
    assign busy       = r_busy;
    assign lost       = r_lost;
    assign spawn_full = r_spawn_full;
    assign overrun    = r_overrun;
    assign chk_req    = r_chk_req;
    assign chk_x      = r_chk_x;
    assign chk_y      = r_chk_y;

endmodule

// File: tb/tb_ball_motion_sched.sv
// Scoreboard bench for ball_motion_sched: a ball-level reference model queues
// expected queries, losses, spawn drops, overruns and end-of-pass snapshots.
module tb_ball_motion_sched;

    localparam int CNT = 3, SCR_W = 640, SCR_H = 480, SIZE = 8;

    typedef struct { int slot; int x; int y; } qry_t;
    typedef struct { logic [CNT*10-1:0] xs; logic [CNT*10-1:0] ys; logic [CNT-1:0] balls; } pass_t;

    logic clk = 1'b0, rst = 1'b1;
    logic frame_tick = 1'b0, spawn = 1'b0;
    logic [9:0] spawn_x = '0, spawn_y = '0;
    logic [3:0] spawn_vx = '0, spawn_vy = '0;
    logic chk_req, chk_ack, chk_hit_x, chk_hit_y;
    logic [9:0] chk_x, chk_y;
    logic [CNT*10-1:0] xs, ys;
    logic [CNT-1:0] balls;
    logic busy, lost, spawn_full, overrun;

    ball_motion_sched #(.CNT(CNT), .SCR_W(SCR_W), .SCR_H(SCR_H), .SIZE(SIZE)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .spawn(spawn),
        .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_vx(spawn_vx), .spawn_vy(spawn_vy),
        .chk_req(chk_req), .chk_x(chk_x), .chk_y(chk_y), .chk_ack(chk_ack),
        .chk_hit_x(chk_hit_x), .chk_hit_y(chk_hit_y), .xs(xs), .ys(ys), .balls(balls),
        .busy(busy), .lost(lost), .spawn_full(spawn_full), .overrun(overrun));

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    int mx[CNT], my[CNT], mvx[CNT], mvy[CNT];
    bit mlive[CNT];
    qry_t q_query[$];
    pass_t q_pass[$];
    logic [1:0] q_hits[$];
    int q_lost[$], q_full[$], q_ovr[$];
    bit mon_en = 1'b0, resp_en = 1'b0, manual_ack = 1'b0;
    int fixed_dly = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int negs(input int v);
        return (v == -8) ? 7 : -v;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < CNT; s++) begin
            mlive[s] = 0; mx[s] = 0; my[s] = 0; mvx[s] = 0; mvy[s] = 0;
        end
        q_query.delete(); q_pass.delete(); q_hits.delete();
        q_lost.delete(); q_full.delete(); q_ovr.delete();
    endtask

    task automatic model_spawn(input int x, input int y, input int vx, input int vy);
        for (int s = 0; s < CNT; s++) begin
            if (!mlive[s]) begin
                mlive[s] = 1; mx[s] = x; my[s] = y; mvx[s] = vx; mvy[s] = vy;
                return;
            end
        end
        q_full.push_back(1);
    endtask

    task automatic model_pass(input bit rnd, input logic [CNT-1:0] fhx, input logic [CNT-1:0] fhy);
        qry_t q; pass_t p;
        int nx, ny, nvx, nvy;
        bit hx, hy;
        for (int s = 0; s < CNT; s++) begin
            if (!mlive[s]) continue;
            nx = mx[s] + mvx[s]; ny = my[s] + mvy[s]; nvx = mvx[s]; nvy = mvy[s];
            if (nx < SIZE) begin nx = SIZE; nvx = negs(nvx); end
            else if (nx > SCR_W - 1 - SIZE) begin nx = SCR_W - 1 - SIZE; nvx = negs(nvx); end
            if (ny < SIZE) begin ny = SIZE; nvy = negs(nvy); end
            if (ny > SCR_H - 1 - SIZE) begin
                mlive[s] = 0; q_lost.push_back(s);
                continue;
            end
            q.slot = s; q.x = nx; q.y = ny;
            q_query.push_back(q);
            hx = rnd ? ($urandom_range(0, 3) == 0) : fhx[s];
            hy = rnd ? ($urandom_range(0, 3) == 0) : fhy[s];
            q_hits.push_back({hy, hx});
            if (!hx) mx[s] = nx;
            if (!hy) my[s] = ny;
            mvx[s] = hx ? negs(nvx) : nvx;
            mvy[s] = hy ? negs(nvy) : nvy;
        end
        for (int s = 0; s < CNT; s++) begin
            p.xs[s*10 +: 10] = 10'(mx[s]);
            p.ys[s*10 +: 10] = 10'(my[s]);
            p.balls[s] = mlive[s];
        end
        q_pass.push_back(p);
    endtask

    task automatic do_spawn(input int x, input int y, input int vx, input int vy);
        @(negedge clk);
        spawn = 1'b1; spawn_x = 10'(x); spawn_y = 10'(y); spawn_vx = 4'(vx); spawn_vy = 4'(vy);
        @(negedge clk);
        spawn = 1'b0;
        model_spawn(x, y, vx, vy);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_tick(input bit rnd, input logic [CNT-1:0] fhx, input logic [CNT-1:0] fhy, input bit ovr);
        int t;
        @(negedge clk);
        frame_tick = 1'b1;
        model_pass(rnd, fhx, fhy);
        @(negedge clk);
        frame_tick = 1'b0;
        if (ovr) begin
            frame_tick = 1'b1;
            q_ovr.push_back(1);
            @(negedge clk);
            frame_tick = 1'b0;
        end
        t = 0;
        while (busy && t < 500) begin @(negedge clk); t++; end
        chk("pass_completes", {63'd0, busy}, 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Collision-checker responder: acks after a programmable delay with queued hits.
    initial begin
        bit waiting = 0;
        int dly = 0;
        logic [1:0] h;
        chk_ack = 1'b0; chk_hit_x = 1'b0; chk_hit_y = 1'b0;
        forever begin
            @(negedge clk);
            chk_ack = manual_ack; chk_hit_x = 1'b0; chk_hit_y = 1'b0;
            if (rst) begin
                waiting = 0;
            end else if (chk_req && resp_en) begin
                if (!waiting) begin
                    waiting = 1;
                    dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
                end
                if (dly == 0) begin
                    chk_ack = 1'b1; waiting = 0;
                    if (q_hits.size() > 0) begin
                        h = q_hits.pop_front();
                        chk_hit_x = h[0]; chk_hit_y = h[1];
                    end
                end else begin
                    dly--;
                end
            end
        end
    end

    // Monitor: compares every DUT-presented event against the scoreboard.
    initial begin
        logic prev_req = 1'b0, prev_busy = 1'b0;
        qry_t q, last_q;
        pass_t p;
        last_q.slot = 0; last_q.x = 0; last_q.y = 0;
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                if (chk_req && !prev_req) begin
                    if (q_query.size() > 0) begin
                        q = q_query.pop_front();
                        last_q = q;
                        chk($sformatf("query_x_s%0d", q.slot), 64'(chk_x), 64'(q.x));
                        chk($sformatf("query_y_s%0d", q.slot), 64'(chk_y), 64'(q.y));
                    end else begin
                        chk("query_unexpected", {44'd0, chk_y, chk_x}, 64'hFFFF_FFFF);
                    end
                end else if (chk_req) begin
                    chk("query_hold", {44'd0, chk_y, chk_x}, {44'd0, 10'(last_q.y), 10'(last_q.x)});
                end
                if (lost) begin
                    if (q_lost.size() > 0) begin void'(q_lost.pop_front()); chk("lost_pulse", 64'(lost), 64'd1); end
                    else chk("lost_unexpected", 64'(lost), 64'd0);
                end
                if (spawn_full) begin
                    if (q_full.size() > 0) begin void'(q_full.pop_front()); chk("spawn_full_pulse", 64'(spawn_full), 64'd1); end
                    else chk("spawn_full_unexpected", 64'(spawn_full), 64'd0);
                end
                if (overrun) begin
                    if (q_ovr.size() > 0) begin void'(q_ovr.pop_front()); chk("overrun_pulse", 64'(overrun), 64'd1); end
                    else chk("overrun_unexpected", 64'(overrun), 64'd0);
                end
                if (prev_busy && !busy) begin
                    if (q_pass.size() > 0) begin
                        p = q_pass.pop_front();
                        chk("pass_xs", 64'(xs), 64'(p.xs));
                        chk("pass_ys", 64'(ys), 64'(p.ys));
                        chk("pass_balls", 64'(balls), 64'(p.balls));
                    end else begin
                        chk("pass_unexpected", 64'(busy), 64'd1);
                    end
                end
            end
            prev_req = chk_req; prev_busy = busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, r;
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_pos", 64'({xs, ys}), 64'd0);
        chk("reset_flags", {56'd0, balls, busy, chk_req, lost, spawn_full, overrun},  64'd0);
        chk("reset_chk_xy", {44'd0, chk_x, chk_y}, 64'd0);

        // Reset in the middle of an outstanding query.
        do_spawn(200, 200, 1, 1);
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        t = 0;
        while (!chk_req && t < 20) begin @(negedge clk); t++; end
        chk("midq_req_up", 64'(chk_req), 64'd1);
        rst = 1'b1;
        #1;
        chk("midq_rst_req", 64'(chk_req), 64'd0);
        chk("midq_rst_state", {61'd0, balls, busy}, 64'd0);
        @(negedge clk); rst = 1'b0;
        model_clear();
        manual_ack = 1'b1;
        @(negedge clk); manual_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_ignored", {60'd0, balls, busy}, 64'd0);
        chk("late_ack_no_req", 64'(chk_req), 64'd0);
        mon_en = 1'b1; resp_en = 1'b1;

        // Four spawns into three slots.
        do_spawn(40, 50, 1, 1);
        chk("fill_slot0", 64'(balls), 64'b001);
        do_spawn(60, 70, 1, 1);
        chk("fill_slot1", 64'(balls), 64'b011);
        do_spawn(80, 90, 1, 1);
        do_spawn(99, 99, 1, 1);
        chk("fill_full", 64'(balls), 64'b111);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_clear();

        // Plain move with no hits.
        do_spawn(100, 200, 2, -3);
        do_tick(1'b0, '0, '0, 1'b0);
        chk("move_slot0", {44'd0, xs[9:0], ys[9:0]}, {44'd0, 10'd102, 10'd197});
        chk("move_balls", 64'(balls), 64'b001);

        // Right-wall clamp then reflected motion.
        do_spawn(633, 240, 3, 0);
        do_tick(1'b0, '0, '0, 1'b0);
        chk("wall_clamp_x", 64'(xs[19:10]), 64'd631);
        do_tick(1'b0, '0, '0, 1'b0);
        chk("wall_reflect_x", 64'(xs[19:10]), 64'd628);

        // Bottom loss.
        do_spawn(50, 470, 0, 3);
        do_tick(1'b0, '0, '0, 1'b0);
        chk("loss_balls", 64'(balls), 64'b011);

        // Three live balls, slow acks, hit_y on slot 1, overrun mid-pass.
        do_spawn(300, 300, -8, -8);
        fixed_dly = 5;
        do_tick(1'b0, 3'b000, 3'b010, 1'b1);
        fixed_dly = -1;
        chk("hit_y_keeps_y", 64'(ys[19:10]), 64'd240);

        // Randomised traffic.
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3) begin
                do_spawn($urandom_range(0, SCR_W - 1), $urandom_range(0, SCR_H - 1),
                         int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8);
            end else begin
                do_tick(1'b1, '0, '0, $urandom_range(0, 9) < 3);
            end
        end

        repeat (4) @(negedge clk);
        chk("queues_drained", 64'(q_query.size() + q_pass.size() + q_lost.size() + q_full.size() + q_ovr.size() + q_hits.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
